// File: rtl/round_robin_scheduler_pkg.sv
// Shared scheduler constants and FSM state encoding.
// PID 0 is reserved for the idle process and never enters the ready set.
package os_sched_pkg;

  localparam int PID_W = 5;
  localparam int NPROC = 32;
  localparam logic [PID_W-1:0] PID_IDLE = '0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PICK   = 2'd1,
    ST_SWITCH = 2'd2,
    ST_RUN    = 2'd3
  } sched_state_t;

endpackage

// File: rtl/round_robin_scheduler_if.sv
// Control/syscall inputs and quantum-timer outputs of the scheduler.
// The master side is the OS/timer environment; the slave side is the scheduler.
interface round_robin_scheduler_if;
  import os_sched_pkg::*;

  logic             ready_set;
  logic [PID_W-1:0] ready_set_pid;
  logic             ready_clr;
  logic [PID_W-1:0] ready_clr_pid;
  logic             yield;
  logic             stall;
  logic             quantum_expired;
  logic             timer_start;
  logic [PID_W-1:0] timer_pid;
  logic             timer_hold;
  logic [PID_W-1:0] cur_pid;
  logic             ctx_switch;
  logic             sched_busy;

  modport master (
    output ready_set, ready_set_pid, ready_clr, ready_clr_pid,
           yield, stall, quantum_expired,
    input  timer_start, timer_pid, timer_hold, cur_pid, ctx_switch, sched_busy
  );

  modport slave (
    input  ready_set, ready_set_pid, ready_clr, ready_clr_pid,
           yield, stall, quantum_expired,
    output timer_start, timer_pid, timer_hold, cur_pid, ctx_switch, sched_busy
  );

endinterface

// File: rtl/round_robin_scheduler_pick.sv
// Combinational circular priority encoder: first ready PID at or after start,
// wrapping around; bit 0 (idle PID) is never selected.
module rr_pick
  import os_sched_pkg::*;
(
  input  logic [NPROC-1:0] mask,
  input  logic [PID_W-1:0] start,
  output logic [PID_W-1:0] pid,
  output logic             found
);

  logic [NPROC-1:0]   m;
  logic [2*NPROC-1:0] dbl;
  logic [NPROC-1:0]   rot;
  logic [PID_W-1:0]   idx;

  always_comb begin
    m     = mask & ~NPROC'(1);
    dbl   = {m, m} >> start;
    rot   = dbl[NPROC-1:0];
    idx   = '0;
    found = 1'b0;
    // Descending scan so the lowest rotated index wins.
    for (int i = NPROC - 1; i >= 0; i--) begin
      if (rot[i]) begin
        idx   = PID_W'(i);
        found = 1'b1;
      end
    end
    pid = idx + start;
  end

endmodule

// File: rtl/round_robin_scheduler.sv
// Round-robin scheduler: ready mask, circular pick, timer start and preemption.
// Outputs are decoded from registered state; ready updates are accepted every cycle.
module round_robin_scheduler
  import os_sched_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  round_robin_scheduler_if.slave  bus
);

  sched_state_t     state, state_nxt;
  logic [NPROC-1:0] mask, mask_nxt;
  logic [PID_W-1:0] cur_pid, cur_nxt;
  logic [PID_W-1:0] next_pid, next_nxt;
  logic [PID_W-1:0] pick_pid;
  logic             pick_found;
  logic             run_event;

  rr_pick u_pick (
    .mask  (mask),
    .start (cur_pid + PID_W'(1)),
    .pid   (pick_pid),
    .found (pick_found)
  );

  // Expiry, yield and self-clear collapse into a single preemption event.
  assign run_event = bus.quantum_expired | bus.yield |
                     (bus.ready_clr && (bus.ready_clr_pid == cur_pid));

  always_comb begin
    mask_nxt = mask;
    if (bus.ready_set) mask_nxt[bus.ready_set_pid] = 1'b1;
    if (bus.ready_clr) mask_nxt[bus.ready_clr_pid] = 1'b0;
    mask_nxt[0] = 1'b0;
  end

  always_comb begin
    state_nxt = state;
    cur_nxt   = cur_pid;
    next_nxt  = next_pid;
    case (state)
      ST_IDLE: begin
        cur_nxt = PID_IDLE;
        if (mask != '0) state_nxt = ST_PICK;
      end
      ST_PICK: begin
        next_nxt = pick_pid;
        cur_nxt  = PID_IDLE;
        state_nxt = pick_found ? ST_SWITCH : ST_IDLE;
      end
      ST_SWITCH: begin
        cur_nxt   = next_pid;
        state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (run_event) state_nxt = ST_PICK;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      mask     <= '0;
      cur_pid  <= PID_IDLE;
      next_pid <= PID_IDLE;
    end else begin
      state    <= state_nxt;
      mask     <= mask_nxt;
      cur_pid  <= cur_nxt;
      next_pid <= next_nxt;
    end
  end

  assign bus.timer_start = (state == ST_SWITCH);
  assign bus.timer_pid   = (state == ST_SWITCH) ? next_pid : PID_IDLE;
  assign bus.timer_hold  = (state == ST_RUN) && bus.stall;
  assign bus.cur_pid     = cur_pid;
  assign bus.ctx_switch  = (state == ST_SWITCH) ||
                           ((state == ST_PICK) && (cur_pid != PID_IDLE));
  assign bus.sched_busy  = (state == ST_PICK) || (state == ST_SWITCH);

endmodule

// File: tb/tb_round_robin_scheduler.sv
// Directed bench for round_robin_scheduler with hand-computed expectations.
module tb_round_robin_scheduler;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  round_robin_scheduler_if bus ();

  round_robin_scheduler dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.ready_set       = 1'b0;
    bus.ready_set_pid   = '0;
    bus.ready_clr       = 1'b0;
    bus.ready_clr_pid   = '0;
    bus.yield           = 1'b0;
    bus.stall           = 1'b0;
    bus.quantum_expired = 1'b0;
  endtask

  task automatic set_ready(input logic [4:0] pid);
    bus.ready_set = 1'b1;
    bus.ready_set_pid = pid;
    nxt();
    bus.ready_set = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    nxt();
    nxt();
    reset = 1'b0;
  endtask

  // Quantum expiry in RUN: PICK next cycle, timer_start two cycles after the event.
  task automatic expire_to(input string tag, input logic [4:0] prev, input logic [4:0] exp);
    bus.quantum_expired = 1'b1;
    nxt();
    bus.quantum_expired = 1'b0;
    check({tag, "_pick_busy"}, 32'(bus.sched_busy), 32'd1);
    check({tag, "_pick_ctx"}, 32'(bus.ctx_switch), 32'd1);
    check({tag, "_pick_cur"}, 32'(bus.cur_pid), 32'(prev));
    nxt();
    check({tag, "_sw_start"}, 32'(bus.timer_start), 32'd1);
    check({tag, "_sw_pid"}, 32'(bus.timer_pid), 32'(exp));
    nxt();
    check({tag, "_run_cur"}, 32'(bus.cur_pid), 32'(exp));
    check({tag, "_run_start"}, 32'(bus.timer_start), 32'd0);
  endtask

  initial begin
    int n_ctx;
    int n_start;
    int n_busy;
    int n_hold;

    idle_inputs();
    do_reset();
    check("rst_cur", 32'(bus.cur_pid), 32'd0);
    check("rst_start", 32'(bus.timer_start), 32'd0);
    check("rst_ctx", 32'(bus.ctx_switch), 32'd0);
    check("rst_busy", 32'(bus.sched_busy), 32'd0);
    check("rst_tpid", 32'(bus.timer_pid), 32'd0);

    // 1: ready_set 3 at cycle 0 -> timer_start at cycle 3, cur_pid at cycle 4
    set_ready(5'd3);
    check("t1_c1_busy", 32'(bus.sched_busy), 32'd0);
    nxt();
    check("t1_c2_busy", 32'(bus.sched_busy), 32'd1);
    check("t1_c2_ctx", 32'(bus.ctx_switch), 32'd0);
    check("t1_c2_start", 32'(bus.timer_start), 32'd0);
    nxt();
    check("t1_c3_start", 32'(bus.timer_start), 32'd1);
    check("t1_c3_pid", 32'(bus.timer_pid), 32'd3);
    nxt();
    check("t1_c4_cur", 32'(bus.cur_pid), 32'd3);
    check("t1_c4_busy", 32'(bus.sched_busy), 32'd0);

    // 2: circular order 3 -> 7 -> 30 -> 3
    set_ready(5'd7);
    set_ready(5'd30);
    check("t2_still_run", 32'(bus.cur_pid), 32'd3);
    expire_to("t2_a", 5'd3, 5'd7);
    expire_to("t2_b", 5'd7, 5'd30);
    expire_to("t2_c", 5'd30, 5'd3);

    // 3: sole ready PID is re-picked with a fresh timer_start
    do_reset();
    set_ready(5'd5);
    nxt();
    nxt();
    nxt();
    check("t3_cur", 32'(bus.cur_pid), 32'd5);
    expire_to("t3", 5'd5, 5'd5);

    // 4: clearing the running sole PID -> IDLE, one ctx_switch, no timer_start
    bus.ready_clr = 1'b1;
    bus.ready_clr_pid = 5'd5;
    nxt();
    bus.ready_clr = 1'b0;
    n_ctx = 0;
    n_start = 0;
    for (int i = 0; i < 4; i++) begin
      n_ctx += int'(bus.ctx_switch);
      n_start += int'(bus.timer_start);
      nxt();
    end
    check("t4_ctx_count", 32'(n_ctx), 32'd1);
    check("t4_start_count", 32'(n_start), 32'd0);
    check("t4_cur", 32'(bus.cur_pid), 32'd0);
    check("t4_busy", 32'(bus.sched_busy), 32'd0);

    // 5a: set and clear of PID 9 in one cycle, and set of PID 0, leave mask empty
    bus.ready_set = 1'b1;
    bus.ready_set_pid = 5'd9;
    bus.ready_clr = 1'b1;
    bus.ready_clr_pid = 5'd9;
    nxt();
    idle_inputs();
    set_ready(5'd0);
    n_busy = 0;
    for (int i = 0; i < 4; i++) begin
      n_busy += int'(bus.sched_busy);
      nxt();
    end
    check("t5_mask_empty", 32'(n_busy), 32'd0);

    // 5b: yield + quantum_expired together -> a single PICK
    set_ready(5'd9);
    nxt();
    nxt();
    nxt();
    check("t5_cur9", 32'(bus.cur_pid), 32'd9);
    set_ready(5'd12);
    bus.yield = 1'b1;
    bus.quantum_expired = 1'b1;
    nxt();
    idle_inputs();
    n_busy = 0;
    n_start = 0;
    for (int i = 0; i < 6; i++) begin
      n_busy += int'(bus.sched_busy);
      n_start += int'(bus.timer_start);
      nxt();
    end
    check("t5_busy_cycles", 32'(n_busy), 32'd2);
    check("t5_start_count", 32'(n_start), 32'd1);
    check("t5_cur12", 32'(bus.cur_pid), 32'd12);

    // 6a: stall for 4 cycles in RUN -> timer_hold exactly those cycles
    n_hold = 0;
    for (int i = 0; i < 6; i++) begin
      bus.stall = (i >= 1 && i <= 4);
      #2;
      n_hold += int'(bus.timer_hold);
      if (i == 2) check("t6_hold_on", 32'(bus.timer_hold), 32'd1);
      if (i == 5) check("t6_hold_off", 32'(bus.timer_hold), 32'd0);
      nxt();
    end
    bus.stall = 1'b0;
    check("t6_hold_count", 32'(n_hold), 32'd4);

    // 6b: reset asserted in SWITCH -> IDLE with all outputs low
    bus.quantum_expired = 1'b1;
    nxt();
    bus.quantum_expired = 1'b0;
    nxt();
    check("t6_in_switch", 32'(bus.timer_start), 32'd1);
    bus.stall = 1'b1;
    reset = 1'b1;
    nxt();
    reset = 1'b0;
    #2;
    check("t6_rst_start", 32'(bus.timer_start), 32'd0);
    check("t6_rst_ctx", 32'(bus.ctx_switch), 32'd0);
    check("t6_rst_busy", 32'(bus.sched_busy), 32'd0);
    check("t6_rst_cur", 32'(bus.cur_pid), 32'd0);
    check("t6_rst_hold", 32'(bus.timer_hold), 32'd0);
    check("t6_rst_tpid", 32'(bus.timer_pid), 32'd0);
    nxt();
    nxt();
    check("t6_mask_cleared", 32'(bus.sched_busy), 32'd0);
    bus.stall = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
